// File: rtl/adc_axis_pkg.sv
// ----------------------------------------------------------------------------
// adc_axis_pkg
// Shared constants, the sample-pair state type and the ADC sample conversion
// used by the ADC-to-AXI-Stream source and its output buffer.
// ----------------------------------------------------------------------------
package adc_axis_pkg;

   localparam int SAMPLE_W = 32;
   localparam int ADC_W    = 8;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } pair_state_e;

   // Offset-binary to two's complement is an MSB flip. The 32-bit result has
   // room for the full gain range: the largest magnitude, 128 << 15, is 2^22.
   function automatic logic signed [SAMPLE_W-1:0] adc_to_sample(
      input logic [ADC_W-1:0] raw,
      input logic [3:0]       sh
   );
      logic signed [ADC_W-1:0]    s_narrow;
      logic signed [SAMPLE_W-1:0] s_wide;
      s_narrow = {~raw[ADC_W-1], raw[ADC_W-2:0]};
      s_wide   = {{(SAMPLE_W-ADC_W){s_narrow[ADC_W-1]}}, s_narrow};
      return s_wide <<< sh;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// ----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock FIFO holding {tlast, tdata} beats for the AXI-Stream output.
// The head entry is presented combinationally (first-word fall-through) and
// reads as zero while the FIFO is empty.
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (empties the FIFO)
//   wr_en_i    write request; refused when full unless a read fires too
//   wr_data_i  entry to write
//   rd_en_i    read request (downstream ready); ignored while empty
//   rd_data_o  head entry, zero when empty
//   empty_o    no entries stored
//   full_o     DEPTH entries stored
// ----------------------------------------------------------------------------
module axis_sync_fifo
   import adc_axis_pkg::*;
#(
   parameter int DEPTH = 8,                 // power of two, at least 2
   parameter int WIDTH = 2*SAMPLE_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_fire;
   logic              rd_fire;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));

   // A write into a full FIFO is still safe when a read retires the head in
   // the same cycle: the write slot is the one being vacated.
   assign rd_fire = rd_en_i && !empty_o;
   assign wr_fire = wr_en_i && (!full_o || rd_fire);

   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (wr_fire && !rd_fire) begin
         count_d = count_q + CNT_W'(1);
      end else if (!wr_fire && rd_fire) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/adc_axis_source.sv
// ----------------------------------------------------------------------------
// adc_axis_source
// Converts an 8-bit offset-binary ADC stream into signed, gain-shifted 32-bit
// samples, packs sample pairs into 64-bit beats, frames them into packets of
// FRAME_LEN beats and streams them out over an AXI-Stream master through a
// small FIFO. The ADC cannot be stalled, so a beat that finds the FIFO full
// is dropped and the sticky overflow flag is raised.
//
// Ports
//   m00_axis_aclk     clock
//   m00_axis_aresetn  asynchronous active-low reset
//   adc_data          ADC sample, offset binary
//   adc_valid         one-cycle sample strobe
//   shift             left-shift gain, sampled with each sample
//   m00_axis_tready   downstream ready
//   m00_axis_tvalid   beat valid
//   m00_axis_tlast    last beat of a frame
//   m00_axis_tdata    {second sample, first sample}
//   m00_axis_tstrb    byte strobes, all ones
//   overflow          sticky: a completed beat was dropped
// ----------------------------------------------------------------------------
module adc_axis_source
   import adc_axis_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,   // must equal 2*SAMPLE_W
   parameter int FRAME_LEN              = 256,
   parameter int FIFO_DEPTH             = 8
) (
   input  logic                                m00_axis_aclk,
   input  logic                                m00_axis_aresetn,
   input  logic [7:0]                          adc_data,
   input  logic                                adc_valid,
   input  logic [3:0]                          shift,
   input  logic                                m00_axis_tready,
   output logic                                m00_axis_tvalid,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                                overflow
);

   localparam int BEAT_W  = 2*SAMPLE_W;
   localparam int ENTRY_W = BEAT_W + 1;
   localparam int FCNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   pair_state_e                state_q, state_d;
   logic signed [SAMPLE_W-1:0] sample;
   logic signed [SAMPLE_W-1:0] first_q, first_d;
   logic [BEAT_W-1:0]          beat_q, beat_d;
   logic                       beat_vld_q, beat_vld_d;
   logic [FCNT_W-1:0]          frame_cnt_q, frame_cnt_d;
   logic                       overflow_q, overflow_d;

   logic                       fifo_empty;
   logic                       fifo_full;
   logic [ENTRY_W-1:0]         fifo_rd_data;
   logic                       rd_fire;
   logic                       wr_accept;
   logic                       tlast_wr;

   // Stage 0: convert each sample and pair it up into a beat.
   assign sample = adc_to_sample(adc_data, shift);

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      beat_d     = beat_q;
      beat_vld_d = 1'b0;
      if (adc_valid) begin
         if (state_q == EVEN) begin
            first_d = sample;
            state_d = ODD;
         end else begin
            beat_d     = {sample, first_q};
            beat_vld_d = 1'b1;
            state_d    = EVEN;
         end
      end
   end

   // Stage 1: frame the completed beat and offer it to the FIFO. A refused
   // write leaves the frame position alone so the next stored beat keeps
   // its slot in the packet.
   assign rd_fire   = m00_axis_tvalid && m00_axis_tready;
   assign wr_accept = beat_vld_q && (!fifo_full || rd_fire);
   assign tlast_wr  = (frame_cnt_q == FCNT_W'(FRAME_LEN-1));

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      overflow_d  = overflow_q;
      if (wr_accept) begin
         frame_cnt_d = tlast_wr ? '0 : frame_cnt_q + FCNT_W'(1);
      end else if (beat_vld_q) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         state_q     <= EVEN;
         beat_vld_q  <= 1'b0;
         frame_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_vld_q  <= beat_vld_d;
         frame_cnt_q <= frame_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   // Sample and beat payloads are qualified by state_q / beat_vld_q, so
   // they need no reset.
   always_ff @(posedge m00_axis_aclk) begin
      first_q <= first_d;
      beat_q  <= beat_d;
   end

   // Stage 2: output buffer feeding the AXI-Stream master.
   axis_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i     (m00_axis_aclk),
      .rst_ni    (m00_axis_aresetn),
      .wr_en_i   (wr_accept),
      .wr_data_i ({tlast_wr, beat_q}),
      .rd_en_i   (m00_axis_tready),
      .rd_data_o (fifo_rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign m00_axis_tvalid = !fifo_empty;
   assign m00_axis_tlast  = fifo_rd_data[BEAT_W];
   assign m00_axis_tdata  = fifo_rd_data[BEAT_W-1:0];
   assign m00_axis_tstrb  = '1;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_adc_axis_source.sv
// ----------------------------------------------------------------------------
// tb_adc_axis_source
// Self-checking bench for adc_axis_source (FRAME_LEN=4, FIFO_DEPTH=8).
// A cycle model predicts every accepted beat and pushes it to a scoreboard
// queue; each scenario task pops and compares beats as the DUT hands them
// over and checks its scenario-specific results.
// ----------------------------------------------------------------------------
module tb_adc_axis_source;

   localparam int DW = 64;
   localparam int FL = 4;
   localparam int FD = 8;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [7:0]    adc_data  = 8'h00;
   logic          adc_valid = 1'b0;
   logic [3:0]    shift     = 4'd0;
   logic          tready    = 1'b0;
   logic          tvalid;
   logic          tlast;
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tstrb;
   logic          overflow;

   adc_axis_source #(
      .C_M00_AXIS_TDATA_WIDTH (DW),
      .FRAME_LEN              (FL),
      .FIFO_DEPTH             (FD)
   ) dut (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (rst_n),
      .adc_data         (adc_data),
      .adc_valid        (adc_valid),
      .shift            (shift),
      .m00_axis_tready  (tready),
      .m00_axis_tvalid  (tvalid),
      .m00_axis_tlast   (tlast),
      .m00_axis_tdata   (tdata),
      .m00_axis_tstrb   (tstrb),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [64:0] exp_q[$];
   logic [64:0] last_beat;
   int          beats;

   // Reference model state.
   int          m_occ   = 0;
   int          m_cnt   = 0;
   bit          m_odd   = 1'b0;
   bit          m_pend  = 1'b0;
   bit          m_ovf   = 1'b0;
   bit          m_rd;
   bit          m_acc;
   logic [31:0] m_first = '0;
   logic [63:0] m_pend_d = '0;

   // Offset binary means value = code - 128; gain is multiplication by 2^s.
   function automatic logic [31:0] mconv(input logic [7:0] d, input logic [3:0] s);
      int v;
      v = (int'(d) - 128) * (1 << s);
      return v[31:0];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_occ  = 0;
         m_cnt  = 0;
         m_odd  = 1'b0;
         m_pend = 1'b0;
         m_ovf  = 1'b0;
         exp_q.delete();
      end else begin
         m_rd  = (m_occ != 0) && tready;
         m_acc = m_pend && ((m_occ < FD) || m_rd);
         if (m_acc) begin
            exp_q.push_back({(m_cnt == FL-1), m_pend_d});
            m_cnt = (m_cnt + 1) % FL;
         end else if (m_pend) begin
            m_ovf = 1'b1;
         end
         m_occ  = m_occ + int'(m_acc) - int'(m_rd);
         m_pend = 1'b0;
         if (adc_valid) begin
            if (!m_odd) begin
               m_first = mconv(adc_data, shift);
               m_odd   = 1'b1;
            end else begin
               m_pend_d = {mconv(adc_data, shift), m_first};
               m_pend   = 1'b1;
               m_odd    = 1'b0;
            end
         end
      end
   end

   task automatic reset_pulse();
      @(posedge clk); #1;
      rst_n = 1'b0; adc_valid = 1'b0; tready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tready = 1'b1; adc_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         adc_data = 8'($urandom_range(0, 255));
      end
      vectors += 5;
      if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
      if (tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %b want 0", tlast); end
      if (tdata !== '0) begin miscompares++; $display("FAIL reset_tdata got %h want 0", tdata); end
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
      if (tstrb !== 8'hFF) begin miscompares++; $display("FAIL reset_tstrb got %h want ff", tstrb); end
      rst_n = 1'b1; adc_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (tvalid !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle_tvalid got %b want 0", tvalid);
         end
      end
   endtask

   task automatic test_pair(input string name, input logic [3:0] sh,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [64:0] want);
      beats = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         adc_valid = (c < 2); adc_data = (c == 0) ? s0 : s1; shift = sh; tready = 1'b1;
         vectors++;
         if (tvalid !== (m_occ != 0) || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL %s_status got tvalid=%b ovf=%b want %b %b", name, tvalid, overflow, m_occ != 0, m_ovf);
         end
         if (tvalid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL %s_beat got %h want none", name, {tlast, tdata});
            end else begin
               if ({tlast, tdata} !== exp_q[0]) begin
                  miscompares++; $display("FAIL %s_beat got %h want %h", name, {tlast, tdata}, exp_q[0]);
               end
               last_beat = {tlast, tdata};
               void'(exp_q.pop_front());
               beats++;
            end
         end
      end
      adc_valid = 1'b0;
      vectors++;
      if (beats !== 1 || last_beat !== want) begin
         miscompares++; $display("FAIL %s_result got %0d beats last=%h want 1 beat %h", name, beats, last_beat, want);
      end
   endtask

   task automatic test_framing();
      reset_pulse();
      beats = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         adc_valid = (c < 16); adc_data = 8'($urandom_range(0, 255));
         shift = 4'($urandom_range(0, 15)); tready = 1'b1;
         vectors++;
         if (tvalid !== (m_occ != 0) || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL framing_status got tvalid=%b ovf=%b want %b %b", tvalid, overflow, m_occ != 0, m_ovf);
         end
         if (tvalid === 1'b1) begin
            vectors += 2;
            if (tlast !== (beats == 3 || beats == 7)) begin
               miscompares++; $display("FAIL framing_tlast beat %0d got %b want %b", beats, tlast, (beats == 3 || beats == 7));
            end
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL framing_beat got %h want none", {tlast, tdata});
            end else begin
               if ({tlast, tdata} !== exp_q[0]) begin
                  miscompares++; $display("FAIL framing_beat got %h want %h", {tlast, tdata}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            beats++;
         end
      end
      adc_valid = 1'b0;
      vectors++;
      if (beats !== 8) begin miscompares++; $display("FAIL framing_count got %0d want 8", beats); end
   endtask

   task automatic test_backpressure();
      reset_pulse();
      beats = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         adc_valid = (c < 38); adc_data = 8'($urandom_range(0, 255));
         shift = 4'($urandom_range(0, 15)); tready = (c >= 40);
         if (c == 40) begin
            vectors++;
            if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow got %b want 1", overflow); end
         end
         vectors++;
         if (tvalid !== (m_occ != 0) || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL bp_status got tvalid=%b ovf=%b want %b %b", tvalid, overflow, m_occ != 0, m_ovf);
         end
         // While stalled the head must stay equal to the expected front.
         if (tvalid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL bp_beat got %h want none", {tlast, tdata});
            end else begin
               if ({tlast, tdata} !== exp_q[0]) begin
                  miscompares++; $display("FAIL bp_beat got %h want %h", {tlast, tdata}, exp_q[0]);
               end
               if (tready) begin
                  void'(exp_q.pop_front());
                  beats++;
               end
            end
         end
      end
      adc_valid = 1'b0;
      vectors += 2;
      if (beats !== 8) begin miscompares++; $display("FAIL bp_count got %0d want 8", beats); end
      if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_sticky got %b want 1", overflow); end
   endtask

   task automatic test_full_read();
      reset_pulse();
      beats = 0;
      for (int c = 0; c < 32; c++) begin
         @(posedge clk); #1;
         adc_valid = (c < 18); adc_data = 8'($urandom_range(0, 255));
         shift = 4'($urandom_range(0, 15)); tready = (c >= 18);
         vectors++;
         if (tvalid !== (m_occ != 0) || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL fullrd_status got tvalid=%b ovf=%b want %b %b", tvalid, overflow, m_occ != 0, m_ovf);
         end
         if (tvalid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL fullrd_beat got %h want none", {tlast, tdata});
            end else begin
               if ({tlast, tdata} !== exp_q[0]) begin
                  miscompares++; $display("FAIL fullrd_beat got %h want %h", {tlast, tdata}, exp_q[0]);
               end
               if (tready) begin
                  void'(exp_q.pop_front());
                  beats++;
               end
            end
         end
      end
      adc_valid = 1'b0;
      vectors += 2;
      if (beats !== 9) begin miscompares++; $display("FAIL fullrd_count got %0d want 9", beats); end
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullrd_overflow got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid_pair();
      logic [7:0] pre [3];
      pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h55;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         adc_valid = (c < 3); adc_data = pre[c % 3]; shift = 4'd0; tready = 1'b0;
      end
      adc_valid = 1'b0;
      vectors++;
      if (tvalid !== 1'b1) begin miscompares++; $display("FAIL midpair_pre_tvalid got %b want 1", tvalid); end
      // Reset takes effect without waiting for a clock edge.
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vectors += 3;
      if (tvalid !== 1'b0) begin miscompares++; $display("FAIL async_tvalid got %b want 0", tvalid); end
      if (tdata !== '0) begin miscompares++; $display("FAIL async_tdata got %h want 0", tdata); end
      if (tlast !== 1'b0) begin miscompares++; $display("FAIL async_tlast got %b want 0", tlast); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      test_pair("midpair", 4'd0, 8'h90, 8'hA0, {1'b0, 64'h00000020_00000010});
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL midpair_overflow got %b want 0", overflow); end
   endtask

   initial begin
      test_reset();
      test_pair("conversion", 4'd0, 8'h80, 8'hFF, {1'b0, 64'h0000007F_00000000});
      test_pair("gain", 4'd2, 8'h00, 8'h81, {1'b0, 64'h00000004_FFFFFE00});
      test_framing();
      test_backpressure();
      test_full_read();
      test_reset_mid_pair();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL leftover_beats got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adc_axis_source.md
ADC_AXIS_SOURCE -- requirements
Module: adc_axis_source

Interface
REQ-001 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 64: output beat width, carrying two 32-bit samples.
REQ-002 SHALL have parameter FRAME_LEN, default 256: beats per AXIS packet.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth in beats, a power of two.
REQ-004 SHALL have port m00_axis_aclk, input, 1 bit: the single clock.
REQ-005 SHALL have port m00_axis_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port adc_data, input, 8 bits: ADC sample in offset-binary.
REQ-007 SHALL have port adc_valid, input, 1 bit: one-cycle sample strobe; the ADC cannot be stalled.
REQ-008 SHALL have port shift, input, 4 bits: left-shift gain applied per sample.
REQ-009 SHALL have port m00_axis_tready, input, 1 bit: downstream ready.
REQ-010 SHALL have port m00_axis_tvalid, output, 1 bit: beat valid.
REQ-011 SHALL have port m00_axis_tlast, output, 1 bit: last beat of a frame.
REQ-012 SHALL have port m00_axis_tdata, output, C_M00_AXIS_TDATA_WIDTH bits: packed sample pair.
REQ-013 SHALL have port m00_axis_tstrb, output, C_M00_AXIS_TDATA_WIDTH/8 bits: byte strobes.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag for a dropped beat.

Function
REQ-015 SHALL convert each sample with adc_valid=1 to signed form as {~adc_data[7], adc_data[6:0]}, sign-extend it to 32 bits, then arithmetic-left-shift it by the shift value sampled in the same cycle.
REQ-016 SHALL fit shifted results without overflow, since the maximum magnitude 128<<15 = 2^22 fits in 32 bits.
REQ-017 SHALL place the first sample of a pair in tdata[31:0] and the second in tdata[63:32].
REQ-018 SHALL implement the pair state machine as follows: EVEN, sample arrives -> hold it, go to ODD; ODD, sample arrives -> complete the beat, go to EVEN.
REQ-019 SHALL write a completed beat to the FIFO in the cycle after the second sample is sampled.
REQ-020 SHALL assert m00_axis_tvalid one cycle after that FIFO write when the FIFO was empty, giving 2 cycles of latency from the second adc_valid.
REQ-021 SHALL transfer a beat only when m00_axis_tvalid and m00_axis_tready are both 1.
REQ-022 SHALL hold tdata and tlast stable while tvalid=1 and tready=0.
REQ-023 SHALL NOT wait for tready before asserting tvalid.
REQ-024 SHALL tie m00_axis_tstrb to all ones.
REQ-025 SHALL keep a beat counter 0..FRAME_LEN-1 that advances on each FIFO write and wraps to 0.
REQ-026 SHALL store tlast=1 with the beat written when the counter equals FRAME_LEN-1.
REQ-027 SHALL, when the FIFO is full with no read in the same cycle, drop the completed beat, leave the beat counter unchanged and set overflow=1.
REQ-028 SHALL, when the FIFO is full and a read fires in the same cycle, accept the write with no drop.
REQ-029 SHALL, on a simultaneous read and write at non-full occupancy, leave occupancy unchanged.
REQ-030 SHALL keep overflow at 1 until reset.
REQ-031 SHALL accept adc_valid on consecutive cycles, i.e. a full-rate stream.

Reset
REQ-032 SHALL, on m00_axis_aresetn=0 (asynchronous), force m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0 and overflow=0.
REQ-033 SHALL, on reset, empty the FIFO, zero the beat counter and set the pair state to EVEN.
REQ-034 SHALL discard a half-formed pair or in-flight beat when reset is asserted mid-frame.
REQ-035 SHALL start the first frame after reset release at beat 0.
REQ-036 SHALL ignore all inputs while reset is asserted.

Structure
REQ-037 SHALL put SAMPLE_W=32, ADC_W=8 and the pair-state enum (EVEN, ODD) in a shared package named adc_axis_pkg.
REQ-038 SHALL implement the buffer as one sub-module, axis_sync_fifo, with 65-bit entries (tlast, tdata), parameterised by FIFO_DEPTH.
REQ-039 SHALL keep conversion, packing and framing in the top module.

Verification
REQ-040 SHALL cover conversion: shift=0, adc_data 0x80 then 0xFF -> tdata=0x0000007F_00000000.
REQ-041 SHALL cover gain: shift=2, adc_data 0x00 then 0x81 -> tdata=0x00000004_FFFFFE00.
REQ-042 SHALL cover framing: FRAME_LEN=4, tready=1, 16 samples -> 8 beats, tlast=1 on beats 3 and 7 only.
REQ-043 SHALL cover backpressure: tready=0 for 40 cycles with samples every cycle -> 8 beats held stable, overflow=1, and after tready=1 exactly 8 beats in order with no duplicates.
REQ-044 SHALL cover full+read: FIFO full with tready=1 in the cycle a beat completes -> no drop, overflow=0.
REQ-045 SHALL cover reset mid-pair: one sample, reset pulse, then 0x90 and 0xA0 -> tdata=0x00000020_00000010, tlast=0, overflow=0.
